mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between the instruction-cache and data-cache refill/writeback engines.
- Sits between both L1 cache controllers and main memory. Accepts one block transfer at a time, forwards it to memory, and returns read data to the requester with a one-cycle done pulse.
- Uses round-robin arbitration. A transfer is never pre-empted once granted.
- A watchdog flags memory transactions that never complete.

Parameters:
ADDR_W, 32, block address width (tag+set index bits as driven by the caches)
BLOCK_W, 128, width of one cache block transferred per transaction
TIMEOUT, 1023, max cycles mem_req may wait for mem_ready before timeout_err sets

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
ic_req  in  1  icache requests a block read; held until ic_done
ic_addr  in  ADDR_W  icache block address, stable while ic_req=1
ic_rdata  out  BLOCK_W  block returned to icache, valid when ic_done=1
ic_done  out  1  one-cycle completion pulse to icache
dc_req  in  1  dcache requests a transfer; held until dc_done
dc_we  in  1  1=writeback (write), 0=refill (read)
dc_addr  in  ADDR_W  dcache block address
dc_wdata  in  BLOCK_W  dirty block for writeback
dc_rdata  out  BLOCK_W  block returned to dcache on reads
dc_done  out  1  one-cycle completion pulse to dcache
mem_req  out  1  transaction to memory active
mem_we  out  1  write transaction
mem_addr  out  ADDR_W  registered block address
mem_wdata  out  BLOCK_W  registered write block
mem_rdata  in  BLOCK_W  memory read block, valid with mem_ready
mem_ready  in  1  memory completes current transaction this cycle
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog error

Behaviour:

States:
- IDLE: sample requests.
- BUSY: transaction outstanding to memory.
- DONE: one cycle in which done pulses.

Reset (reset=1 at an edge):
- state=IDLE, last_grant=IC (so dcache wins the first tie).
- wait_cnt=0, timeout_err=0.
- All outputs 0, including ic_rdata, dc_rdata, mem_addr and mem_wdata.
- Reset mid-transaction aborts it: mem_req is 0 the cycle after reset, and no done is issued.

IDLE arbitration:
- If only one req is high, grant it.
- If both are high, grant the requester not equal to last_grant.
- On grant:
  - latch owner, address, we (IC forces we=0) and wdata into the mem_* registers;
  - update last_grant;
  - go to BUSY.
- No req: stay in IDLE.

BUSY:
- mem_req=1; mem_addr, mem_we and mem_wdata are held constant.
- Each cycle with mem_ready=0, wait_cnt increments, saturating at TIMEOUT.
- When wait_cnt reaches TIMEOUT, timeout_err sets and stays set until reset. The arbiter keeps waiting.
- mem_ready=1:
  - on a read, latch mem_rdata into the owner's rdata register (the other rdata is unchanged);
  - on a write, both rdata registers are unchanged;
  - clear wait_cnt and go to DONE.

DONE:
- Owner's done=1 for exactly this cycle; mem_req=0.
- Requests are ignored this cycle. The requester must drop req (or present a new request) at the edge ending DONE.
- Next state: IDLE.

Timing:
- Latency: req high in cycle t (IDLE) → mem_req high in t+1.
- mem_ready in cycle k → done and rdata valid in k+1 → IDLE in k+2.
- Back-to-back grant: mem_req high again in k+3.
- rdata registers retain their value after done until the next read completes for that owner.

Boundary rules:
- mem_ready while IDLE or DONE is ignored.
- A request that deasserts while in BUSY does not abort the transaction.
- Never both done signals in the same cycle; never more than one outstanding transaction.
- Both req held continuously: grants alternate D, I, D, I.

Test Plan:
1. Reset, then ic_req=1, ic_addr=0x40; memory returns 0xAAAA…(128b) after 3 cycles → mem_req high 1 cycle after req with mem_we=0 and mem_addr=0x40; ic_done pulses 1 cycle after mem_ready; ic_rdata=0xAAAA…; dc_done never asserts.
2. dc_req=1, dc_we=1, dc_addr=0x80, dc_wdata=0x1234…; mem_ready after 1 cycle → mem_we=1 and mem_wdata=0x1234… held through BUSY; dc_done pulses; dc_rdata unchanged (still 0 after reset).
3. Both req asserted together right after reset, each held until its done → dcache granted first, icache second; a continued dual request alternates D, I, D, I; done pulses never overlap.
4. TIMEOUT=8, request issued, mem_ready withheld 20 cycles → timeout_err=1 from the 9th wait cycle onward; transaction then completes normally with done; timeout_err stays 1 until reset.
5. Reset asserted 2 cycles into BUSY → next cycle mem_req=0, busy=0, no done pulse; next request after reset is granted normally with the dcache-first tie rule.
6. mem_ready pulsed while IDLE and during DONE → no state change, no done, rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signal bundle for the shared memory port arbiter.
// The arbiter attaches through the slave modport; caches and memory drive the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128
);
  logic               ic_req;
  logic [ADDR_W-1:0]  ic_addr;
  logic [BLOCK_W-1:0] ic_rdata;
  logic               ic_done;

  logic               dc_req;
  logic               dc_we;
  logic [ADDR_W-1:0]  dc_addr;
  logic [BLOCK_W-1:0] dc_wdata;
  logic [BLOCK_W-1:0] dc_rdata;
  logic               dc_done;

  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;
  logic               mem_ready;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_rdata, ic_done, dc_rdata, dc_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_rdata, ic_done, dc_rdata, dc_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between icache and dcache engines.
// One non-preemptible block transfer at a time, with a sticky watchdog on memory stalls.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  state_t             state_q;
  owner_t             lastGrant_q;
  owner_t             owner_q;
  logic [CNT_W-1:0]   waitCnt_q;
  logic [CNT_W-1:0]   waitCnt_d;
  logic               grantDc;

  logic               memReq_q;
  logic               memWe_q;
  logic [ADDR_W-1:0]  memAddr_q;
  logic [BLOCK_W-1:0] memWdata_q;
  logic [BLOCK_W-1:0] icRdata_q;
  logic [BLOCK_W-1:0] dcRdata_q;
  logic               icDone_q;
  logic               dcDone_q;
  logic               busy_q;
  logic               timeoutErr_q;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grantDc = bus.dc_req && (!bus.ic_req || (lastGrant_q == OWN_IC));
    if (waitCnt_q == CNT_W'(TIMEOUT)) begin
      waitCnt_d = waitCnt_q;
    end else begin
      waitCnt_d = waitCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lastGrant_q  <= OWN_IC;
      owner_q      <= OWN_IC;
      waitCnt_q    <= '0;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      icRdata_q    <= '0;
      dcRdata_q    <= '0;
      icDone_q     <= 1'b0;
      dcDone_q     <= 1'b0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      icDone_q <= 1'b0;
      dcDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            state_q  <= BUSY;
            busy_q   <= 1'b1;
            memReq_q <= 1'b1;
            if (grantDc) begin
              owner_q     <= OWN_DC;
              lastGrant_q <= OWN_DC;
              memWe_q     <= bus.dc_we;
              memAddr_q   <= bus.dc_addr;
              memWdata_q  <= bus.dc_wdata;
            end else begin
              owner_q     <= OWN_IC;
              lastGrant_q <= OWN_IC;
              memWe_q     <= 1'b0;
              memAddr_q   <= bus.ic_addr;
            end
          end
        end

        BUSY: begin
          if (bus.mem_ready) begin
            state_q   <= DONE;
            memReq_q  <= 1'b0;
            waitCnt_q <= '0;
            icDone_q  <= (owner_q == OWN_IC);
            dcDone_q  <= (owner_q == OWN_DC);
            if (!memWe_q) begin
              if (owner_q == OWN_DC) begin
                dcRdata_q <= bus.mem_rdata;
              end else begin
                icRdata_q <= bus.mem_rdata;
              end
            end
          end else begin
            // The watchdog only reports; the transfer keeps waiting for memory.
            waitCnt_q <= waitCnt_d;
            if (waitCnt_d == CNT_W'(TIMEOUT)) begin
              timeoutErr_q <= 1'b1;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.ic_rdata  = icRdata_q;
  assign bus.dc_rdata  = dcRdata_q;
  assign bus.ic_done   = icDone_q;
  assign bus.dc_done   = dcDone_q;
  assign busy          = busy_q;
  assign timeout_err   = timeoutErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: the bench plays both caches and memory
// and predicts grants, done pulses, read data and watchdog state from a transaction-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  logic timeout_err;

  int errors = 0;
  int checks = 0;

  // Model state: who won last, what each cache should currently hold, sticky watchdog.
  bit                 mLastDc;
  logic [BLOCK_W-1:0] mIcRdata;
  logic [BLOCK_W-1:0] mDcRdata;
  bit                 mErr;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .BLOCK_W(BLOCK_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic checkCycle(input string tag, input bit expReq, input bit expBusy,
                            input bit expIcDone, input bit expDcDone, input bit expErr);
    checkOutput({tag, ".mem_req"},     bus.mem_req,  expReq);
    checkOutput({tag, ".busy"},        busy,         expBusy);
    checkOutput({tag, ".ic_done"},     bus.ic_done,  expIcDone);
    checkOutput({tag, ".dc_done"},     bus.dc_done,  expDcDone);
    checkOutput({tag, ".ic_rdata"},    bus.ic_rdata, mIcRdata);
    checkOutput({tag, ".dc_rdata"},    bus.dc_rdata, mDcRdata);
    checkOutput({tag, ".timeout_err"}, timeout_err,  expErr);
  endtask

  task automatic checkResetState(input string tag);
    mLastDc  = 1'b0;
    mIcRdata = '0;
    mDcRdata = '0;
    mErr     = 1'b0;
    checkCycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, ".mem_we"},    bus.mem_we,    1'b0);
    checkOutput({tag, ".mem_addr"},  bus.mem_addr,  '0);
    checkOutput({tag, ".mem_wdata"}, bus.mem_wdata, '0);
  endtask

  // One arbitration round, entered at a negedge with the arbiter idle. Each enabled cache
  // presents one request; the winner of a tie is the one that did not win last time.
  task automatic applyStimulus(input bit icOn, input bit dcOn,
                               input logic [ADDR_W-1:0] icA, input logic [ADDR_W-1:0] dcA,
                               input bit dcWe, input logic [BLOCK_W-1:0] dcWd,
                               input int lat, input logic [BLOCK_W-1:0] rdVal);
    bit order[2];
    int n;
    bus.ic_req    = icOn;
    bus.ic_addr   = icA;
    bus.dc_req    = dcOn;
    bus.dc_we     = dcWe;
    bus.dc_addr   = dcA;
    bus.dc_wdata  = dcWd;
    bus.mem_ready = 1'b0;
    if (icOn && dcOn) begin
      order[0] = !mLastDc;
      order[1] = mLastDc;
      n = 2;
    end else begin
      order[0] = dcOn;
      order[1] = 1'b0;
      n = (icOn || dcOn) ? 1 : 0;
    end

    if (n == 0) begin
      for (int i = 0; i < 3; i++) begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = rand128();
        tick();
        checkCycle("noreq", 1'b0, 1'b0, 1'b0, 1'b0, mErr);
      end
    end

    for (int t = 0; t < n; t++) begin
      bit isDc;
      bit isWr;
      logic [BLOCK_W-1:0] rv;
      isDc    = order[t];
      isWr    = isDc && dcWe;
      rv      = (t == 0) ? rdVal : ~rdVal;
      mLastDc = isDc;
      for (int c = 1; c <= lat + 1; c++) begin
        tick();
        checkCycle("busy", 1'b1, 1'b1, 1'b0, 1'b0, mErr || (c - 1 >= TIMEOUT));
        checkOutput("mem_addr", bus.mem_addr, isDc ? dcA : icA);
        checkOutput("mem_we", bus.mem_we, isWr);
        if (isWr) checkOutput("mem_wdata", bus.mem_wdata, dcWd);
        if (c == 2 && $urandom_range(0, 1) == 1) begin
          if (isDc) bus.dc_req = 1'b0;
          else      bus.ic_req = 1'b0;
        end
        bus.mem_ready = (c == lat + 1);
        bus.mem_rdata = (c == lat + 1) ? rv : rand128();
      end
      if (lat >= TIMEOUT) mErr = 1'b1;
      if (!isWr) begin
        if (isDc) mDcRdata = rv;
        else      mIcRdata = rv;
      end
      tick();
      checkCycle("done", 1'b0, 1'b1, !isDc, isDc, mErr);
      if (isDc) bus.dc_req = 1'b0;
      else      bus.ic_req = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = rand128();
      tick();
      checkCycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, mErr);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = rand128();
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    reset         = 1'b1;
    bus.ic_req    = 1'b0;
    bus.ic_addr   = '0;
    bus.dc_req    = 1'b0;
    bus.dc_we     = 1'b0;
    bus.dc_addr   = '0;
    bus.dc_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) tick();
    checkResetState("reset");
    reset = 1'b0;
    tick();

    $display("[TB] icache read of 0x40");
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, '0, 2, {4{32'hAAAAAAAA}});

    $display("[TB] dcache writeback of 0x80");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h80, 1'b1, {8{16'h1234}}, 1, rand128());

    $display("[TB] dual requests alternate");
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, 1'b1, 32'h100 + r, 32'h200 + r, 1'($urandom_range(0, 1)),
                    rand128(), int'($urandom_range(0, 3)), rand128());
    end

    $display("[TB] watchdog on a stalled read");
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, '0, 20, rand128());

    $display("[TB] randomized rounds");
    for (int r = 0; r < 40; r++) begin
      a1 = $urandom;
      a2 = $urandom;
      if (a1 == a2) a2 = a1 ^ 32'h1;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, a2,
                    1'($urandom_range(0, 1)), rand128(), int'($urandom_range(0, 4)), rand128());
    end

    $display("[TB] reset during a transfer");
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h500;
    tick();
    checkOutput("pre_reset.mem_req", bus.mem_req, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    checkResetState("mid_reset");
    reset      = 1'b0;
    bus.dc_req = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    checkCycle("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h600, 32'h700, 1'b0, rand128(), 1, rand128());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
